uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one uart_tx byte transmitter among N_REQ byte-stream requesters.
//   Grants round-robin at message granularity. A requester keeps the grant until it sends a byte
//   flagged last, or until its lock times out. Drives the uart_tx data/data_valid/tx_ack handshake:
//   one rising data_valid edge per byte, and data_valid is dropped after each ack.
//   Sits between the command/response producers and uart_tx.
// PARAMETERS
//   N_REQ         2     number of requesters (1..8)
//   LOCK_TIMEOUT  4096  idle cycles before a held lock is forcibly released; 0 = never time out
// PORTS
//   clk            in   1        system clock
//   nrst           in   1        asynchronous active-low reset
//   req_valid      in   N_REQ    requester i has a byte on req_data[8i+7:8i]
//   req_data       in   8*N_REQ  byte per requester
//   req_last       in   N_REQ    byte is the final byte of its message
//   req_ready      out  N_REQ    1-cycle pulse: byte of requester i captured
//   tx_data        out  8        byte to uart_tx data
//   tx_data_valid  out  1        to uart_tx data_valid
//   tx_ack         in   1        from uart_tx tx_ack
//   grant_id       out  clog2(max(N_REQ,2))  index of current/last granted requester
//   locked         out  1        a message is in progress (grant held)
//   busy           out  1        state != ARB
// BEHAVIOUR
// - Clock, reset and reset values
//   - Single clock domain; nrst is asynchronous assert, synchronous-release assumed upstream.
//   - Reset values: tx_data=0, tx_data_valid=0, req_ready=0, grant_id=0, locked=0, busy=0,
//     rr_ptr=0, timeout counter=0, state=ARB.
// - FSM states
//   - ARB: tx_data_valid=0.
//     - If locked: consider only grant_id.
//     - Else: pick the first valid requester scanning from rr_ptr upward, with modulo N_REQ wrap.
//     - On a pick i (same cycle): tx_data<=req_data[i], req_ready[i]=1, grant_id<=i,
//       locked<=~req_last[i], rr_ptr<=(i+1)%N_REQ, go SEND.
//   - SEND: tx_data_valid=1, tx_data held stable. When tx_ack=1, go DROP.
//   - DROP: tx_data_valid=0. When tx_ack=0, go ARB. Guarantees >=1 low cycle of data_valid
//     between bytes so uart_tx sees a fresh rising edge.
// - Latency
//   - Byte captured in cycle t -> tx_data_valid high at t+1.
//   - Minimum spacing between req_ready pulses = SEND + DROP + ARB cycles, which is >=3.
// - Lock timeout
//   - Counter runs only in ARB while locked and req_valid[grant_id]=0; it clears on any capture.
//   - When the counter reaches LOCK_TIMEOUT: locked<=0, and arbitration resumes next cycle from
//     rr_ptr.
//   - LOCK_TIMEOUT=0: counter disabled; lock held indefinitely.
// - Boundary conditions
//   - Simultaneous requests: round-robin order; no requester is starved over N_REQ messages.
//   - Unlocked single-byte messages (req_last=1) rotate the grant after every byte.
//   - N_REQ=1: rr_ptr stays 0; lock logic still functions.
//   - req_valid dropping while in SEND/DROP has no effect; the byte was already captured.
//   - tx_ack already high on entry to SEND (stale ack): DROP drains it before the next capture.
//   - Reset mid-byte: outputs return to reset values immediately; tx_data_valid=0 aborts the
//     handshake; uart_tx is reset by the same nrst.
//   - cts low stalls only inside uart_tx; the arbiter waits in SEND indefinitely.
// TESTING
//   1. N_REQ=2, only req0 sends 0x41(last=1) -> req_ready[0] pulse, tx_data=0x41,
//      one data_valid rise, ack -> data_valid low, back to ARB; grant_id=0, locked=0.
//   2. Both valid, req0 msg {0x10,0x11(last)}, req1 msg {0x20(last)} -> uart order
//      0x10,0x11,0x20; req1 is never granted while locked=1.
//   3. Both continuously valid, all bytes last=1 -> grants alternate 0,1,0,1; rr_ptr wraps.
//   4. LOCK_TIMEOUT=8: req0 sends 0x55(last=0) then idles; req1 valid 0x66 -> locked drops
//      exactly 8 ARB cycles later; 0x66 captured next cycle.
//   5. Hold tx_ack high 5 cycles after data_valid drop -> arbiter stays in DROP, no new capture
//      until tx_ack=0.
//   6. Assert nrst during SEND -> tx_data_valid=0, locked=0, state=ARB the same cycle;
//      after release the pending request is re-arbitrated from rr_ptr=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares a single uart_tx byte transmitter among N_REQ byte-stream
//   requesters. Grants rotate round-robin at message granularity: once a
//   requester wins, it keeps the grant until it sends a byte flagged last,
//   or until it has left the lock idle for LOCK_TIMEOUT arbitration cycles.
//   Each byte is presented with its own rising edge of tx_data_valid.
//   tx_data_valid is then held low until uart_tx releases tx_ack.
//
// Ports
//   clk            system clock
//   nrst           asynchronous active-low reset
//   req_valid      per-requester byte available
//   req_data       per-requester byte, requester i on [8i+7:8i]
//   req_last       per-requester "final byte of message" flag
//   req_ready      per-requester capture pulse (same cycle as the capture edge)
//   tx_data        byte towards uart_tx
//   tx_data_valid  data_valid towards uart_tx
//   tx_ack         tx_ack from uart_tx
//   grant_id       current / most recent granted requester
//   locked         a multi-byte message is in progress
//   busy           a byte handshake is in flight (not arbitrating)

module uart_tx_arbiter #(
    parameter int N_REQ        = 2,
    parameter int LOCK_TIMEOUT = 4096,
    localparam int GW          = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_data_valid,
    input  logic               tx_ack,
    output logic [GW-1:0]      grant_id,
    output logic               locked,
    output logic               busy
);

    // The lock counter only needs to reach LOCK_TIMEOUT-1: the idle cycle
    // seen at that count is the one that releases the lock.
    localparam int          CW         = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam bit          TIMEOUT_EN = (LOCK_TIMEOUT > 0);
    localparam logic [CW-1:0] CNT_LAST = (LOCK_TIMEOUT > 0) ? CW'(LOCK_TIMEOUT - 1) : '0;
    localparam logic [GW-1:0] LAST_IDX = GW'(N_REQ - 1);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        SEND = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [GW-1:0]   rr_ptr_reg;
    logic [CW-1:0]   lock_cnt_reg;

    logic [7:0]      req_byte [N_REQ];
    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic [GW-1:0]   next_ptr;
    logic [GW:0]     scan_sum;
    logic [GW-1:0]   scan_idx;
    logic            capture;
    logic            lock_idle;
    logic            lock_expire;

    // Split the flat data bus into one byte per requester and build the
    // capture pulses. req_ready is qualified by nrst so that no requester
    // sees a capture while the arbiter is held in reset.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign req_byte[gi]  = req_data[8*gi +: 8];
        assign req_ready[gi] = nrst & capture & (pick_idx == GW'(gi));
    end

    // Requester selection. A held lock restricts the choice to the lock
    // owner. Otherwise scan N_REQ slots starting at rr_ptr with wrap. The scan
    // runs from the farthest offset down to the nearest, so the nearest valid
    // requester is the last assignment and wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        if (locked) begin
            if (req_valid[grant_id]) begin
                pick_found = 1'b1;
                pick_idx   = grant_id;
            end
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                scan_sum = {1'b0, rr_ptr_reg} + (GW+1)'(k);
                if (scan_sum >= (GW+1)'(N_REQ)) begin
                    scan_sum = scan_sum - (GW+1)'(N_REQ);
                end
                scan_idx = scan_sum[GW-1:0];
                if (req_valid[scan_idx]) begin
                    pick_found = 1'b1;
                    pick_idx   = scan_idx;
                end
            end
        end
    end

    assign capture     = (state_reg == ARB) && pick_found;
    assign next_ptr    = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
    // The lock timer only ages while the owner is silent in ARB. Cycles spent
    // in SEND or DROP waiting on uart_tx never count against the owner.
    assign lock_idle   = TIMEOUT_EN && (state_reg == ARB) && locked && !req_valid[grant_id];
    assign lock_expire = (lock_cnt_reg == CNT_LAST);

    // Handshake sequencing. DROP waits for tx_ack to fall, so a stale ack can
    // never be mistaken for the acknowledge of the next byte.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ARB:     if (pick_found) state_next = SEND;
            SEND:    if (tx_ack)     state_next = DROP;
            DROP:    if (!tx_ack)    state_next = ARB;
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg     <= ARB;
            tx_data       <= 8'h00;
            tx_data_valid <= 1'b0;
            grant_id      <= '0;
            locked        <= 1'b0;
            busy          <= 1'b0;
            rr_ptr_reg    <= '0;
            lock_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            // Registered copies of the state decode keep these outputs
            // glitch-free towards uart_tx.
            tx_data_valid <= (state_next == SEND);
            busy          <= (state_next != ARB);
            if (capture) begin
                tx_data      <= req_byte[pick_idx];
                grant_id     <= pick_idx;
                locked       <= ~req_last[pick_idx];
                rr_ptr_reg   <= next_ptr;
                lock_cnt_reg <= '0;
            end else if (lock_idle) begin
                if (lock_expire) begin
                    locked       <= 1'b0;
                    lock_cnt_reg <= '0;
                end else begin
                    lock_cnt_reg <= lock_cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N_REQ=3, LOCK_TIMEOUT=8).
// The requester drivers feed per-requester byte queues. A simple uart_tx
// responder drives tx_ack. The bench pushes each expected byte, with its
// requester and lock state, into a scoreboard queue. A monitor pops one
// entry on every rising edge of tx_data_valid and compares it with the DUT.

module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int TO = 8;
    localparam int GW = 2;

    logic             clk;
    logic             nrst;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [7:0]       tx_data;
    logic             tx_data_valid;
    logic             tx_ack;
    logic [GW-1:0]    grant_id;
    logic             locked;
    logic             busy;

    uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(TO)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_ack        (tx_ack),
        .grant_id      (grant_id),
        .locked        (locked),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [GW-1:0] id;
        logic          last;
        logic [7:0]    data;
    } exp_t;

    exp_t  exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    logic [8:0] mem [N][64];
    int         head [N];
    int         tail [N];
    bit         pop_pending [N];

    bit  ack_enable  = 1'b1;
    int  ack_hold    = -1;   // -1: random 0..2 cycles of ack after data_valid drops
    int  ack_lat_max = 2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input int id, input logic last, input logic [7:0] d);
        mem[id][tail[id]] = {last, d};
        tail[id]++;
    endtask

    task automatic exp_push(input int id, input logic last, input logic [7:0] d);
        exp_t e;
        e.id   = GW'(id);
        e.last = last;
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic bit all_consumed();
        bit r = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (head[i] != tail[i] || pop_pending[i]) r = 1'b0;
        end
        return r;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        while (c < budget && !(exp_q.size() == 0 && busy == 1'b0 && all_consumed())) begin
            @(negedge clk); #2;
            c++;
        end
        check({name, "_done_in_budget"}, 32'(c < budget), 32'd1);
    endtask

    task automatic reset_dut();
        @(posedge clk); #2;
        nrst = 1'b0;
        @(posedge clk); #2;
        nrst = 1'b1;
    endtask

    // Requester drivers: present the queue head and consume it after a capture.
    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            pop_pending[i] = 1'b0;
        end
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (pop_pending[i]) begin
                    head[i]++;
                    pop_pending[i] = 1'b0;
                end
                if (head[i] < tail[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = mem[i][head[i]][7:0];
                    req_last[i]        = mem[i][head[i]][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
            #1;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) pop_pending[i] = 1'b1;
            end
        end
    end

    // uart_tx stand-in: ack after a random latency, hold the ack past the data_valid drop.
    initial begin
        tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_data_valid && ack_enable) begin
                int w;
                int hold;
                repeat ($urandom_range(0, ack_lat_max)) @(negedge clk);
                tx_ack = 1'b1;
                w = 0;
                while (tx_data_valid && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                if (w >= 200) check("data_valid_drop_after_ack", 32'(tx_data_valid), 32'd0);
                hold = (ack_hold < 0) ? int'($urandom_range(0, 2)) : ack_hold;
                repeat (hold) @(negedge clk);
                tx_ack = 1'b0;
            end
        end
    end

    // Scoreboard monitor: one entry per rising edge of tx_data_valid.
    initial begin
        logic       prev_dv;
        logic [7:0] cur_data;
        int         nbyte;
        prev_dv  = 1'b0;
        cur_data = 8'h00;
        nbyte    = 0;
        forever begin
            @(negedge clk);
            if (tx_data_valid && !prev_dv) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_byte: got req%0d data %02h, expected none", grant_id, tx_data);
                    cur_data = tx_data;
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("byte %0d: req%0d data=%02h locked=%0b (expect req%0d data=%02h last=%0b)",
                             nbyte, grant_id, tx_data, locked, e.id, e.data, e.last);
                    check("tx_data", 32'(tx_data), 32'(e.data));
                    check("grant_id", 32'(grant_id), 32'(e.id));
                    check("locked", 32'(locked), 32'(!e.last));
                    cur_data = e.data;
                end
                nbyte++;
            end else if (tx_data_valid && prev_dv) begin
                check("tx_data_hold", 32'(tx_data), 32'(cur_data));
            end
            prev_dv = tx_data_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int w;
        nrst = 1'b1;
        #1 nrst = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        #2;
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_data_valid", 32'(tx_data_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #2;
        nrst = 1'b1;

        // Single-byte message from req0
        push_byte(0, 1'b1, 8'h41);
        exp_push(0, 1'b1, 8'h41);
        wait_idle("t1", 200);
        check("t1_grant_id", 32'(grant_id), 32'd0);
        check("t1_locked", 32'(locked), 32'd0);
        check("t1_tx_data_valid", 32'(tx_data_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);

        // Locked two-byte message wins over a competing single byte
        reset_dut();
        push_byte(0, 1'b0, 8'h10);
        push_byte(0, 1'b1, 8'h11);
        push_byte(1, 1'b1, 8'h20);
        exp_push(0, 1'b0, 8'h10);
        exp_push(0, 1'b1, 8'h11);
        exp_push(1, 1'b1, 8'h20);
        wait_idle("t2", 300);

        // Single-byte messages alternate 0,1,0,1 with rr_ptr wrapping past idle req2
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            push_byte(0, 1'b1, 8'hA0 + 8'(k));
            push_byte(1, 1'b1, 8'hB0 + 8'(k));
            exp_push(0, 1'b1, 8'hA0 + 8'(k));
            exp_push(1, 1'b1, 8'hB0 + 8'(k));
        end
        wait_idle("t3", 500);

        // Lock timeout: req0 leaves its message unfinished, req1 waits
        reset_dut();
        push_byte(0, 1'b0, 8'h55);
        push_byte(1, 1'b1, 8'h66);
        exp_push(0, 1'b0, 8'h55);
        exp_push(1, 1'b1, 8'h66);
        w = 0;
        while (!locked && w < 100) begin
            @(negedge clk); #2;
            w++;
        end
        check("t4_lock_taken", 32'(locked), 32'd1);
        cnt = 0;
        w = 0;
        while (w < 100) begin
            @(negedge clk); #2;
            w++;
            if (!locked) break;
            if (!busy) cnt++;
        end
        check("t4_idle_arb_cycles", 32'(cnt), 32'(TO));
        check("t4_req1_ready_after_timeout", 32'(req_ready), 32'b010);
        wait_idle("t4", 300);

        // tx_ack held high after data_valid drops: no new capture until it falls
        ack_hold = 5;
        push_byte(0, 1'b1, 8'h71);
        push_byte(0, 1'b1, 8'h72);
        exp_push(0, 1'b1, 8'h71);
        exp_push(0, 1'b1, 8'h72);
        w = 0;
        while (!tx_data_valid && w < 100) begin
            @(negedge clk); #2;
            w++;
        end
        w = 0;
        while (tx_data_valid && w < 100) begin
            @(negedge clk); #2;
            w++;
        end
        for (int k = 0; k < 5; k++) begin
            check("t5_stall_busy", 32'(busy), 32'd1);
            check("t5_stall_no_ready", 32'(req_ready), 32'd0);
            @(negedge clk); #2;
        end
        ack_hold = -1;
        wait_idle("t5", 300);

        // Reset while a locked message is in SEND
        ack_enable = 1'b0;
        push_byte(1, 1'b0, 8'h81);
        push_byte(1, 1'b1, 8'h82);
        exp_push(1, 1'b0, 8'h81);
        w = 0;
        while (!tx_data_valid && w < 100) begin
            @(negedge clk); #2;
            w++;
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        nrst = 1'b0;
        #1;
        check("t6_rst_tx_data_valid", 32'(tx_data_valid), 32'd0);
        check("t6_rst_locked", 32'(locked), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_grant_id", 32'(grant_id), 32'd0);
        push_byte(0, 1'b1, 8'h91);
        @(negedge clk); #2;
        check("t6_no_ready_in_reset", 32'(req_ready), 32'd0);
        exp_push(0, 1'b1, 8'h91);
        exp_push(1, 1'b1, 8'h82);
        @(posedge clk); #2;
        nrst = 1'b1;
        ack_enable = 1'b1;
        wait_idle("t6", 300);

        // Randomized traffic: every requester has a backlog of messages, so the
        // uart byte order is the messages interleaved round-robin 0,1,2,0,1,2...
        reset_dut();
        ack_lat_max = 3;
        for (int m = 0; m < 6; m++) begin
            for (int i = 0; i < N; i++) begin
                int len;
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++) begin
                    logic [7:0] d;
                    logic       l;
                    d = 8'($urandom);
                    l = (b == len - 1);
                    push_byte(i, l, d);
                    exp_push(i, l, d);
                end
            end
        end
        wait_idle("rand", 5000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
